// File: rtl/rr_mux4_pkg.sv
// mux4_pkg: shared constants and helpers for the rr_mux4 4-to-1 merge.
//   NUM_CH     - number of input channels
//   SEL_W      - width of a channel index
//   MAX_DATA_W - widest payload ch_slice() can extract
//   ch_slice() - returns channel idx's payload, low-aligned, from packed data
package mux4_pkg;

    localparam int NUM_CH     = 4;
    localparam int SEL_W      = 2;
    localparam int MAX_DATA_W = 64;

    // The caller zero-extends its packed bus to the fixed width and truncates
    // the result back to its own payload width, so one helper serves any
    // DATA_W up to MAX_DATA_W.
    function automatic logic [NUM_CH*MAX_DATA_W-1:0] ch_slice(
        input logic [NUM_CH*MAX_DATA_W-1:0] packed_data,
        input int unsigned                  data_w,
        input logic [SEL_W-1:0]             idx
    );
        return packed_data >> (data_w * idx);
    endfunction

endpackage

// File: rtl/rr_mux4_if.sv
// rr_mux4_if: bundle of the four input channels and the single output channel.
//   in_valid/in_data/in_ready      - four producer handshakes (channel i in bit i /
//                                    slice [i*DATA_W +: DATA_W])
//   out_valid/out_data/out_sel     - merged, registered output with source index
//   out_ready                      - downstream ready
//   modport master : producers + consumer side (drives inputs and out_ready)
//   modport slave  : the merge itself
interface rr_mux4_if
    import mux4_pkg::*;
#(
    parameter int DATA_W = 8
) ();

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_mux4_arbiter.sv
// rr_arbiter4: combinational round-robin arbiter for four requesters.
//   req     - request vector
//   ptr     - index with highest priority this cycle; search ascends mod 4
//   en      - gates the one-hot grant (index is still computed)
//   gnt     - one-hot grant, zero when disabled or no request
//   gnt_idx - index of the winning requester (0 when no request)
module rr_arbiter4
    import mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        // Index arithmetic wraps naturally in SEL_W bits.
        for (int off = 0; off < NUM_CH; off++) begin
            idx = ptr + SEL_W'(off);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux4.sv
// rr_mux4: round-robin 4-to-1 merge with a registered, source-tagged output.
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - rr_mux4_if.slave: in_valid/in_data/in_ready (four producers),
//         out_valid/out_data/out_sel/out_ready (merged output)
// in_ready is combinational and may follow out_ready in the same cycle.
module rr_mux4
    import mux4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    rr_mux4_if.slave   bus
);

    logic [SEL_W-1:0]  ptr;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [SEL_W-1:0]  sel_p1;

    logic              load_p0;
    logic [NUM_CH-1:0] gnt_p0;
    logic [SEL_W-1:0]  gnt_idx_p0;
    logic              take_p0;
    logic [DATA_W-1:0] data_p0;

    // ---- stage 0: arbitration and payload select ----
    // The output register can take a word when empty or draining this cycle.
    assign load_p0 = !vld_p1 || bus.out_ready;

    rr_arbiter4 u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .en      (load_p0 && !rst),
        .gnt     (gnt_p0),
        .gnt_idx (gnt_idx_p0)
    );

    assign take_p0  = |gnt_p0;
    assign data_p0  = DATA_W'(ch_slice((NUM_CH*MAX_DATA_W)'(bus.in_data), DATA_W, gnt_idx_p0));
    assign bus.in_ready = gnt_p0;

    // ---- stage 1: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            ptr     <= '0;
        end else if (load_p0) begin
            if (take_p0) begin
                vld_p1  <= 1'b1;
                data_p1 <= data_p0;
                sel_p1  <= gnt_idx_p0;
                ptr     <= gnt_idx_p0 + SEL_W'(1);
            end else begin
                // Nothing to load: empty the register, keep last data/sel.
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_sel   = sel_p1;

endmodule

// File: tb/tb_rr_mux4.sv
// tb_rr_mux4: directed vector table plus a rotation/scoreboard sequence for rr_mux4.
module tb_rr_mux4;
    import mux4_pkg::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux4_if #(.DATA_W(DW)) bus ();

    rr_mux4 #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_os;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    vec_t vt[$];

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic o,
                       input logic [3:0] er, input logic eov, input logic [7:0] eod,
                       input logic [1:0] eos);
        vec_t x;
        x.rst = r; x.vld = v; x.data = d; x.ordy = o;
        x.exp_rdy = er; x.exp_ov = eov; x.exp_od = eod; x.exp_os = eos;
        vt.push_back(x);
    endtask

    initial begin
        int n_ch[4];
        int k;
        int acc_cnt;
        int out_cnt;
        logic [3:0] acc;

        rst = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        //   rst vld      data          ordy  rdy      ov  od     os
        // reset state
        add(1, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 2'd0);
        // single channel 2, then idle drain
        add(0, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2'd2);
        add(0, 4'b0000, 32'h0,        1, 4'b0000, 0, 8'hA5, 2'd2);
        add(0, 4'b0000, 32'h0,        1, 4'b0000, 0, 8'hA5, 2'd2);
        // ptr=3, only ch1 -> skip to 1, ptr=2; then ch0+ch3 -> 3, wrap, then 0
        add(0, 4'b0010, 32'h00007700, 1, 4'b0010, 1, 8'h77, 2'd1);
        add(0, 4'b1001, 32'hC30000C0, 1, 4'b1000, 1, 8'hC3, 2'd3);
        add(0, 4'b0001, 32'h000000C0, 1, 4'b0001, 1, 8'hC0, 2'd0);
        add(0, 4'b0000, 32'h0,        1, 4'b0000, 0, 8'hC0, 2'd0);
        // reset with all valid: in_ready must stay 0
        add(1, 4'b1111, 32'h13121110, 1, 4'b0000, 0, 8'h00, 2'd0);
        // all four valid: rotation without bubbles
        add(0, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h10, 2'd0);
        add(0, 4'b1111, 32'h13121110, 1, 4'b0010, 1, 8'h11, 2'd1);
        add(0, 4'b1111, 32'h13121110, 1, 4'b0100, 1, 8'h12, 2'd2);
        add(0, 4'b1111, 32'h13121110, 1, 4'b1000, 1, 8'h13, 2'd3);
        add(0, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h10, 2'd0);
        // backpressure: ch0 loaded, three stall cycles, then ch3
        add(1, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 2'd0);
        add(0, 4'b1001, 32'hB30000B0, 0, 4'b0001, 1, 8'hB0, 2'd0);
        add(0, 4'b1000, 32'hB3000000, 0, 4'b0000, 1, 8'hB0, 2'd0);
        add(0, 4'b1000, 32'hB3000000, 0, 4'b0000, 1, 8'hB0, 2'd0);
        add(0, 4'b1000, 32'hB3000000, 0, 4'b0000, 1, 8'hB0, 2'd0);
        add(0, 4'b1000, 32'hB3000000, 1, 4'b1000, 1, 8'hB3, 2'd3);
        add(0, 4'b0000, 32'h0,        1, 4'b0000, 0, 8'hB3, 2'd3);
        // reset mid-stall discards the pending word; ch1 granted first after
        add(0, 4'b0100, 32'h005A0000, 0, 4'b0100, 1, 8'h5A, 2'd2);
        add(0, 4'b0000, 32'h0,        0, 4'b0000, 1, 8'h5A, 2'd2);
        add(1, 4'b0100, 32'h005A0000, 0, 4'b0000, 0, 8'h00, 2'd0);
        add(0, 4'b0010, 32'h00003C00, 0, 4'b0010, 1, 8'h3C, 2'd1);
        add(0, 4'b0000, 32'h0,        1, 4'b0000, 0, 8'h3C, 2'd1);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            rst           = vt[i].rst;
            bus.in_valid  = vt[i].vld;
            bus.in_data   = vt[i].data;
            bus.out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vt[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vt[i].exp_ov));
            chk($sformatf("v%0d out_data", i),  32'(bus.out_data),  32'(vt[i].exp_od));
            chk($sformatf("v%0d out_sel", i),   32'(bus.out_sel),   32'(vt[i].exp_os));
        end

        // Fairness + scoreboard: all four always requesting, each producer
        // advances its payload on acceptance, out_ready gaps every third cycle.
        // The k-th output must come from channel k%4 carrying its (k/4)-th word.
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) n_ch[i] = 0;
        k = 0; acc_cnt = 0; out_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            bus.in_valid  = 4'b1111;
            bus.out_ready = (cyc % 3) != 2;
            for (int i = 0; i < 4; i++) bus.in_data[i*8 +: 8] = 8'(i*64 + n_ch[i]);
            #1;
            acc = bus.in_valid & bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("seq out_sel k%0d", k),  32'(bus.out_sel),  32'(k % 4));
                chk($sformatf("seq out_data k%0d", k), 32'(bus.out_data), 32'((k % 4)*64 + k/4));
                k++;
                out_cnt++;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (acc[i]) begin
                n_ch[i]++;
                acc_cnt++;
            end
        end
        // drain with a bounded budget
        @(negedge clk);
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("drain out_sel k%0d", k),  32'(bus.out_sel),  32'(k % 4));
                chk($sformatf("drain out_data k%0d", k), 32'((bus.out_data)), 32'((k % 4)*64 + k/4));
                k++;
                out_cnt++;
            end
            @(negedge clk);
        end
        chk("seq out_valid after drain", 32'(bus.out_valid), 32'd0);
        chk("seq accepts vs outputs", 32'(out_cnt), 32'(acc_cnt));
        // 40 cycles, every third with out_ready low: 27 transfers expected
        chk("seq accept count", 32'(acc_cnt), 32'd27);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
